// File: rtl/buscaminas_pkg.sv
// Shared types and helpers for the minesweeper board generator.
package buscaminas_pkg;

    typedef logic [3:0] cell_t;

    localparam cell_t CELL_EMPTY  = 4'd0;
    localparam cell_t CELL_MARKED = 4'd10;
    localparam cell_t CELL_BOMB   = 4'd11;
    localparam int    BOARD_DIM   = 8;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {IDLE, CLEAR, PLACE, COUNT, DONE} gen_state_t;

    // Read-slot offsets as {dx, dy}, each a 2-bit two's complement value.
    // Slot 0 is the centre, slots 1..8 walk the neighbours row-major.
    localparam logic [8:0][3:0] NB_OFFSET = {
        4'b0101, 4'b0100, 4'b0111,   // slot 8 (+1,+1), 7 (+1,0), 6 (+1,-1)
        4'b0001, 4'b0011,            // slot 5 (0,+1),  4 (0,-1)
        4'b1101, 4'b1100, 4'b1111,   // slot 3 (-1,+1), 2 (-1,0), 1 (-1,-1)
        4'b0000                      // slot 0 centre
    };

    function automatic logic [3:0] slot_offset(input logic [3:0] slot);
        return (slot <= 4'd8) ? NB_OFFSET[slot] : 4'b0000;
    endfunction

    // True when the neighbour for this slot lies on the board.
    function automatic logic nb_valid(input logic [2:0] cx, input logic [2:0] cy,
                                      input logic [3:0] slot);
        logic [3:0] off;
        logic [4:0] nx;
        logic [4:0] ny;
        off = slot_offset(slot);
        nx  = {2'b00, cx} + {{3{off[3]}}, off[3:2]};
        ny  = {2'b00, cy} + {{3{off[1]}}, off[1:0]};
        return (nx[4:3] == 2'b00) && (ny[4:3] == 2'b00);
    endfunction

    // Neighbour address {x, y}; off-board neighbours fall back to the centre.
    function automatic logic [5:0] nb_addr(input logic [2:0] cx, input logic [2:0] cy,
                                           input logic [3:0] slot);
        logic [3:0] off;
        logic [4:0] nx;
        logic [4:0] ny;
        off = slot_offset(slot);
        nx  = {2'b00, cx} + {{3{off[3]}}, off[3:2]};
        ny  = {2'b00, cy} + {{3{off[1]}}, off[1:0]};
        if ((nx[4:3] == 2'b00) && (ny[4:3] == 2'b00))
            return {nx[2:0], ny[2:0]};
        return {cx, cy};
    endfunction

endpackage

// File: rtl/board_generator_if.sv
// Control handshake and board RAM port between the generator and its host.
interface board_generator_if;
    logic                  start;
    logic                  seed_load;
    logic [15:0]           seed;
    logic                  busy;
    logic                  done;
    logic [6:0]            bombs_placed;
    logic [2:0]            rd_x;
    logic [2:0]            rd_y;
    buscaminas_pkg::cell_t rd_data;
    logic                  wr_en;
    logic [2:0]            wr_x;
    logic [2:0]            wr_y;
    buscaminas_pkg::cell_t wr_data;

    modport master (
        output start, seed_load, seed, rd_data,
        input  busy, done, bombs_placed, rd_x, rd_y, wr_en, wr_x, wr_y, wr_data
    );

    modport slave (
        input  start, seed_load, seed, rd_data,
        output busy, done, bombs_placed, rd_x, rd_y, wr_en, wr_x, wr_y, wr_data
    );
endinterface

// File: rtl/board_generator_lfsr16.sv
// 16-bit Galois LFSR used to pick bomb candidates; a zero seed is replaced.
module lfsr16
    import buscaminas_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        advance,
    input  logic [15:0] seed,
    output logic [5:0]  cell_sel
);
    logic [15:0] value;

    assign cell_sel = value[5:0];

    // Load has priority; otherwise step once per advance request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            value <= LFSR_SEED;
        else if (load)
            value <= (seed == 16'h0000) ? LFSR_SEED : seed;
        else if (advance)
            value <= {1'b0, value[15:1]} ^ (value[0] ? LFSR_TAPS : 16'h0000);
    end
endmodule

// File: rtl/board_generator.sv
// Clears the 8x8 board, scatters bombs, then writes every cell's adjacent-bomb count.
module board_generator
    import buscaminas_pkg::*;
#(
    parameter int          NUM_BOMBS = 10,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    board_generator_if.slave  bus
);
    localparam logic [6:0] NUM_BOMBS_W = 7'(NUM_BOMBS);

    if (NUM_BOMBS < 0 || NUM_BOMBS > 63) begin : g_bad_num_bombs
        $error("board_generator: NUM_BOMBS must lie within 0..63");
    end

    gen_state_t state;
    logic [5:0] cell_idx;     // {x, y} of the cell being cleared or counted
    logic [3:0] phase;        // cycle within a cell during COUNT (0..9)
    logic       place_b;      // 0: attempt cycle A, 1: attempt cycle B
    logic [2:0] cand_x;
    logic [2:0] cand_y;
    logic [3:0] acc;
    logic [3:0] acc_next;
    logic       hit;
    logic       centre_bomb;
    logic [6:0] bombs_placed;
    logic [5:0] lfsr_sel;
    logic [2:0] cx;
    logic [2:0] cy;

    assign cx = cell_idx[5:3];
    assign cy = cell_idx[2:0];

    lfsr16 #(.LFSR_SEED(LFSR_SEED)) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     ((state == IDLE) && bus.seed_load),
        .advance  ((state == PLACE) && !place_b),
        .seed     (bus.seed),
        .cell_sel (lfsr_sel)
    );

    // Data returned now belongs to the slot issued one cycle earlier.
    always_comb begin
        hit      = (state == COUNT) && (phase >= 4'd2) && nb_valid(cx, cy, phase - 4'd1)
                   && (bus.rd_data == CELL_BOMB);
        acc_next = acc + {3'b000, hit};
    end

    // Sequencer: state, cell walk, bomb placement and neighbour accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cell_idx     <= '0;
            phase        <= '0;
            place_b      <= 1'b0;
            cand_x       <= '0;
            cand_y       <= '0;
            acc          <= '0;
            centre_bomb  <= 1'b0;
            bombs_placed <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state        <= CLEAR;
                        cell_idx     <= '0;
                        bombs_placed <= '0;
                    end
                end
                CLEAR: begin
                    cell_idx <= cell_idx + 6'd1;
                    if (cell_idx == 6'd63) begin
                        state   <= (NUM_BOMBS == 0) ? COUNT : PLACE;
                        place_b <= 1'b0;
                        phase   <= '0;
                        acc     <= '0;
                    end
                end
                PLACE: begin
                    if (!place_b) begin
                        cand_x  <= lfsr_sel[2:0];
                        cand_y  <= lfsr_sel[5:3];
                        place_b <= 1'b1;
                    end else begin
                        place_b <= 1'b0;
                        if (bus.rd_data != CELL_BOMB) begin
                            bombs_placed <= bombs_placed + 7'd1;
                            if (bombs_placed + 7'd1 == NUM_BOMBS_W)
                                state <= COUNT;
                        end
                    end
                end
                COUNT: begin
                    if (phase == 4'd1)
                        centre_bomb <= (bus.rd_data == CELL_BOMB);
                    if (phase == 4'd9) begin
                        phase    <= '0;
                        acc      <= '0;
                        cell_idx <= cell_idx + 6'd1;
                        if (cell_idx == 6'd63)
                            state <= DONE;
                    end else begin
                        phase <= phase + 4'd1;
                        acc   <= acc_next;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy         = (state == CLEAR) || (state == PLACE) || (state == COUNT);
    assign bus.done         = (state == DONE);
    assign bus.bombs_placed = bombs_placed;

    // RAM port decode; the placement write depends on the data read this cycle.
    always_comb begin
        bus.rd_x    = 3'd0;
        bus.rd_y    = 3'd0;
        bus.wr_en   = 1'b0;
        bus.wr_x    = 3'd0;
        bus.wr_y    = 3'd0;
        bus.wr_data = CELL_EMPTY;
        unique case (state)
            CLEAR: begin
                bus.wr_en = 1'b1;
                bus.wr_x  = cx;
                bus.wr_y  = cy;
            end
            PLACE: begin
                if (!place_b) begin
                    bus.rd_x = lfsr_sel[2:0];
                    bus.rd_y = lfsr_sel[5:3];
                end else begin
                    bus.wr_en   = (bus.rd_data != CELL_BOMB);
                    bus.wr_x    = cand_x;
                    bus.wr_y    = cand_y;
                    bus.wr_data = CELL_BOMB;
                end
            end
            COUNT: begin
                if (phase <= 4'd8) begin
                    {bus.rd_x, bus.rd_y} = nb_addr(cx, cy, phase);
                end else begin
                    bus.wr_en   = !centre_bomb;
                    bus.wr_x    = cx;
                    bus.wr_y    = cy;
                    bus.wr_data = acc_next;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_board_generator.sv
// Bench: three generators (10, 0 and 63 bombs) against a behavioural board model.
module tb_board_generator;
    import buscaminas_pkg::*;

    localparam logic [15:0] DEF_SEED = 16'hACE1;
    localparam int          MAX_CYC  = 20000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start_s [3];
    logic        sl_s    [3];
    logic        pre_s   [3];
    logic [15:0] seed_s  [3];
    logic        busy_o  [3];
    logic        done_o  [3];
    logic        wren_o  [3];
    logic [6:0]  bp_o    [3];
    logic [2:0]  rx_o [3], ry_o [3], wx_o [3], wy_o [3];
    logic [3:0]  wd_o    [3];
    logic [3:0]  rd_q    [3];
    logic [3:0]  mem     [3][64];

    int          n_tests, n_fail;
    logic [15:0] mlfsr [3];
    int          exp_board [64];
    int          exp_att;

    board_generator_if bif [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NB = (g == 0) ? 10 : ((g == 1) ? 0 : 63);
        board_generator #(.NUM_BOMBS(NB), .LFSR_SEED(DEF_SEED)) u_dut (
            .clk(clk), .rst(rst), .bus(bif[g])
        );
        assign bif[g].start     = start_s[g];
        assign bif[g].seed_load = sl_s[g];
        assign bif[g].seed      = seed_s[g];
        assign bif[g].rd_data   = rd_q[g];
        assign busy_o[g] = bif[g].busy;
        assign done_o[g] = bif[g].done;
        assign wren_o[g] = bif[g].wr_en;
        assign bp_o[g]   = bif[g].bombs_placed;
        assign rx_o[g]   = bif[g].rd_x;
        assign ry_o[g]   = bif[g].rd_y;
        assign wx_o[g]   = bif[g].wr_x;
        assign wy_o[g]   = bif[g].wr_y;
        assign wd_o[g]   = bif[g].wr_data;
    end

    // Board RAMs with one-cycle read latency; address = x*8 + y.
    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            rd_q[g] <= mem[g][{rx_o[g], ry_o[g]}];
            if (pre_s[g]) begin
                for (int i = 0; i < 64; i++) mem[g][i] <= 4'd10;
            end else if (wren_o[g]) begin
                mem[g][{wx_o[g], wy_o[g]}] <= wd_o[g];
            end
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int nb_of(input int g);
        return (g == 0) ? 10 : ((g == 1) ? 0 : 63);
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    // Reference: scatter bombs from the seed sequence, then count neighbours.
    task automatic model_gen(input int g);
        int placed, x, y, cnt;
        placed  = 0;
        exp_att = 0;
        for (int i = 0; i < 64; i++) exp_board[i] = 0;
        while (placed < nb_of(g)) begin
            x = int'(mlfsr[g][2:0]);
            y = int'(mlfsr[g][5:3]);
            mlfsr[g] = lfsr_step(mlfsr[g]);
            exp_att++;
            if (exp_board[x*8+y] != 11) begin
                exp_board[x*8+y] = 11;
                placed++;
            end
        end
        for (int i = 0; i < 64; i++) begin
            if (exp_board[i] != 11) begin
                cnt = 0;
                for (int dx = -1; dx <= 1; dx++)
                    for (int dy = -1; dy <= 1; dy++)
                        if ((dx != 0 || dy != 0) && (i/8+dx) >= 0 && (i/8+dx) < 8 &&
                            (i%8+dy) >= 0 && (i%8+dy) < 8 &&
                            exp_board[(i/8+dx)*8 + (i%8+dy)] == 11)
                            cnt++;
                exp_board[i] = cnt;
            end
        end
    endtask

    task automatic run_gen(input int g, input bit load, input logic [15:0] sd,
                           input int disturb_at, input int abort_at, output int cyc);
        int viol;
        bit fin;
        viol = 0; cyc = 0; fin = 0;
        @(negedge clk);
        start_s[g] = 1'b1; sl_s[g] = load; seed_s[g] = sd;
        if (load) mlfsr[g] = (sd == 16'h0) ? DEF_SEED : sd;
        @(posedge clk);
        while (!fin) begin
            @(negedge clk);
            start_s[g] = 1'b0; sl_s[g] = 1'b0;
            cyc++;
            if (wren_o[g] && !busy_o[g]) viol++;
            if (cyc == abort_at) begin
                check("abort_busy_before", busy_o[g], 1);
                #1 rst = 1'b1;
                #1;
                check("abort_busy", busy_o[g], 0);
                check("abort_wren", wren_o[g], 0);
                check("abort_done", done_o[g], 0);
                check("abort_bp", bp_o[g], 0);
                for (int k = 0; k < 3; k++) mlfsr[k] = DEF_SEED;
                @(negedge clk);
                rst = 1'b0;
                cyc = -1;
                fin = 1;
            end else if (done_o[g]) begin
                fin = 1;
            end else if (cyc == disturb_at) begin
                start_s[g] = 1'b1; sl_s[g] = 1'b1; seed_s[g] = 16'($urandom);
            end else if (cyc >= MAX_CYC) begin
                fin = 1;
            end
        end
        if (cyc >= 0) begin
            check("done_pulse", done_o[g], 1);
            check("wr_only_busy", viol, 0);
            @(negedge clk);
            check("done_one_cycle", done_o[g], 0);
            check("idle_after_done", busy_o[g], 0);
        end
    endtask

    task automatic verify(input int g, input int cyc, input string tag);
        int bad, bombs, self_bad, cnt;
        model_gen(g);
        check({tag, "_cycles"}, cyc, 705 + 2*exp_att);
        bad = 0; bombs = 0; self_bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (mem[g][i] !== 4'(exp_board[i])) bad++;
            if (mem[g][i] === 4'd11) begin
                bombs++;
            end else begin
                cnt = 0;
                for (int dx = -1; dx <= 1; dx++)
                    for (int dy = -1; dy <= 1; dy++)
                        if ((dx != 0 || dy != 0) && (i/8+dx) >= 0 && (i/8+dx) < 8 &&
                            (i%8+dy) >= 0 && (i%8+dy) < 8 &&
                            mem[g][(i/8+dx)*8 + (i%8+dy)] === 4'd11)
                            cnt++;
                if (mem[g][i] !== 4'(cnt)) self_bad++;
            end
        end
        check({tag, "_board"}, bad, 0);
        check({tag, "_bombs"}, bombs, nb_of(g));
        check({tag, "_selfcount"}, self_bad, 0);
        check({tag, "_bombs_placed"}, int'(bp_o[g]), nb_of(g));
    endtask

    initial begin
        int cyc, diff, left, ex, nonzero;
        int prev [64];
        logic [15:0] s;
        n_tests = 0; n_fail = 0;
        rst = 1'b1;
        for (int g = 0; g < 3; g++) begin
            start_s[g] = 1'b0; sl_s[g] = 1'b0; pre_s[g] = 1'b0; seed_s[g] = 16'h0;
            mlfsr[g] = DEF_SEED;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check("rst_busy", busy_o[g], 0);
            check("rst_done", done_o[g], 0);
            check("rst_wren", wren_o[g], 0);
            check("rst_bp", bp_o[g], 0);
        end
        rst = 1'b0;

        run_gen(0, 1'b1, 16'h1234, -1, -1, cyc);
        verify(0, cyc, "seed1234");

        @(negedge clk); pre_s[1] = 1'b1;
        @(negedge clk); pre_s[1] = 1'b0;
        run_gen(1, 1'b0, 16'h0, -1, -1, cyc);
        check("nobomb_cycles_705", cyc, 705);
        verify(1, cyc, "nobomb");
        nonzero = 0;
        for (int i = 0; i < 64; i++) if (mem[1][i] !== 4'd0) nonzero++;
        check("nobomb_all_zero", nonzero, 0);

        s = 16'($urandom_range(1, 65535));
        run_gen(2, 1'b1, s, -1, -1, cyc);
        verify(2, cyc, "full63");
        left = -1;
        for (int i = 0; i < 64; i++) if (mem[2][i] !== 4'd11) left = i;
        if (left >= 0) begin
            ex = ((left/8 == 0 || left/8 == 7) && (left%8 == 0 || left%8 == 7)) ? 3 :
                 ((left/8 == 0 || left/8 == 7 || left%8 == 0 || left%8 == 7) ? 5 : 8);
            check("full63_last_cell", int'(mem[2][left]), ex);
        end else begin
            check("full63_free_cell_found", left, 0);
        end

        for (int r = 0; r < 3; r++) begin
            s = 16'($urandom);
            run_gen(0, 1'b1, s, (r == 0) ? 30 : ((r == 1) ? 300 : -1), -1, cyc);
            verify(0, cyc, "rand");
        end

        run_gen(0, 1'b1, 16'h0000, -1, -1, cyc);
        verify(0, cyc, "zero_seed");

        for (int i = 0; i < 64; i++) prev[i] = int'(mem[0][i]);
        run_gen(0, 1'b0, 16'h0, -1, -1, cyc);
        verify(0, cyc, "b2b");
        diff = 0;
        for (int i = 0; i < 64; i++) if (int'(mem[0][i]) != prev[i]) diff++;
        check("b2b_differs", int'(diff > 0), 1);

        s = 16'($urandom_range(1, 65535));
        run_gen(0, 1'b1, s, -1, 400, cyc);
        run_gen(0, 1'b1, s, -1, -1, cyc);
        verify(0, cyc, "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
